// File: rtl/simple_adder_arb_sv_if.sv
// Request/response bundle for the shared-adder arbiter: N operand-pair
// requesters on one side, a single tagged sum channel on the other.
interface simple_adder_arb_sv_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x_0;
  logic [N*W-1:0] req_x_1;
  logic           resp_valid;
  logic           resp_ready;
  logic [IW-1:0]  resp_id;
  logic [W-1:0]   resp_result;
  logic           resp_carry;

  modport master (
    output req_valid, req_x_0, req_x_1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_carry
  );

  modport slave (
    input  req_valid, req_x_0, req_x_1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_carry
  );
endinterface

// File: rtl/simple_adder_arb_sv.sv
// Round-robin arbiter sharing one W-bit adder among N requesters; the granted
// sum is registered and returned with its requester id and carry-out.
module simple_adder_arb_sv #(
  parameter int W = 8,
  parameter int N = 4
) (
  input logic                 clk,
  input logic                 resetn,
  simple_adder_arb_sv_if.slave bus
);
  localparam int IW = $clog2(N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [W-1:0]  result_q, result_d;
  logic          carry_q, carry_d;

  logic          accept;
  logic          grant_found;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] cand_idx;
  int            cand_pos;
  logic [N-1:0]  req_ready_c;
  logic [W:0]    sum_c;

  logic [W-1:0]  x0_a [N];
  logic [W-1:0]  x1_a [N];

  function automatic logic [W:0] add_carry(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign x0_a[i] = bus.req_x_0[i*W +: W];
    assign x1_a[i] = bus.req_x_1[i*W +: W];
  end

  // A held response blocks new grants until the consumer takes it.
  assign accept = (state_q == IDLE) || bus.resp_ready;

  // Search ptr, ptr+1, ... wrapping; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    cand_pos    = 0;
    for (int k = 0; k < N; k++) begin
      cand_pos = int'(ptr_q) + k;
      if (cand_pos >= N) cand_pos = cand_pos - N;
      cand_idx = IW'(cand_pos);
      if (!grant_found && bus.req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign sum_c = add_carry(x0_a[grant_idx], x1_a[grant_idx]);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    result_d    = result_q;
    carry_d     = carry_q;
    req_ready_c = '0;
    if (accept) begin
      if (grant_found) begin
        req_ready_c[grant_idx] = 1'b1;
        state_d  = HOLD;
        id_d     = grant_idx;
        result_d = sum_c[W-1:0];
        carry_d  = sum_c[W];
        ptr_d    = (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.resp_valid  = (state_q == HOLD);
  assign bus.resp_id     = id_q;
  assign bus.resp_result = result_q;
  assign bus.resp_carry  = carry_q;

endmodule

// File: tb/tb_simple_adder_arb_sv.sv
// Randomized and directed bench for simple_adder_arb_sv: a requester-level
// reference model feeds a response scoreboard drained by an independent monitor.
module tb_simple_adder_arb_sv;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic resetn = 1'b0;

  simple_adder_arb_sv_if #(.W(W), .N(N)) bus();
  simple_adder_arb_sv #(.W(W), .N(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  res;
    logic          c;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  bit          pend [N];
  logic [W-1:0] ox0 [N];
  logic [W-1:0] ox1 [N];
  int          m_ptr;
  bit          m_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    pend[i] = 1'b1;
    ox0[i]  = a;
    ox1[i]  = b;
  endtask

  task automatic post_rand(input int i);
    post(i, W'($urandom), W'($urandom));
  endtask

  task automatic drive_inputs(input bit rr);
    logic [N-1:0]   v;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    for (int i = 0; i < N; i++) begin
      v[i]         = pend[i];
      a[i*W +: W]  = ox0[i];
      b[i*W +: W]  = ox1[i];
    end
    bus.req_valid  = v;
    bus.req_x_0    = a;
    bus.req_x_1    = b;
    bus.resp_ready = rr;
  endtask

  // One clock: drive, check combinational grant against the model, advance model.
  task automatic step(input bit rr);
    int           g;
    int           s;
    logic [N-1:0] expr;
    exp_t         e;
    drive_inputs(rr);
    #1;
    chk("resp_valid", 32'(bus.resp_valid), 32'(m_hold));
    g = -1;
    if (!m_hold || rr) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && pend[i]) g = i;
      end
    end
    expr = '0;
    if (g >= 0) expr[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(expr));
    if (!m_hold || rr) begin
      if (g >= 0) begin
        s     = int'(ox0[g]) + int'(ox1[g]);
        e.id  = IW'(g);
        e.res = W'(s % (1 << W));
        e.c   = (s >= (1 << W));
        sb.push_back(e);
        pend[g] = 1'b0;
        m_ptr   = (g + 1) % N;
        m_hold  = 1'b1;
      end else begin
        m_hold = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    m_ptr  = 0;
    m_hold = 1'b0;
    sb.delete();
  endtask

  // Reset asserted between edges; the response must drop without a clock.
  task automatic apply_reset();
    resetn = 1'b0;
    #1;
    chk("async_reset_valid", 32'(bus.resp_valid), 32'd0);
    model_clear();
    drive_inputs(1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && bus.resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got response id %0d, required none", bus.resp_id);
        end else begin
          e = sb[0];
          chk("resp_id", 32'(bus.resp_id), 32'(e.id));
          chk("resp_result", 32'(bus.resp_result), 32'(e.res));
          chk("resp_carry", 32'(bus.resp_carry), 32'(e.c));
          if (bus.resp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stimulus
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      ox0[i]  = '0;
      ox1[i]  = '0;
    end
    m_ptr  = 0;
    m_hold = 1'b0;
    drive_inputs(1'b0);
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("rst_resp_result", 32'(bus.resp_result), 32'd0);
    chk("rst_resp_carry", 32'(bus.resp_carry), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Single request, then idle.
    post(0, 8'h12, 8'h34);
    step(1'b1);
    step(1'b1);
    step(1'b1);

    // Overflow wraps with carry.
    post(2, 8'hFF, 8'h01);
    step(1'b1);
    post(2, 8'h80, 8'h80);
    step(1'b1);
    step(1'b1);

    // Round robin from a fresh pointer with everyone requesting.
    apply_reset();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) post_rand(i);
      step(1'b1);
    end

    // Backpressure: response held, no grants, then handoff plus new grant.
    for (int r = 0; r < 5; r++) step(1'b0);
    step(1'b1);
    for (int r = 0; r < 8; r++) step(1'b1);

    // Pointer skip and wrap.
    apply_reset();
    post_rand(0); step(1'b1);
    post_rand(1); step(1'b1);
    post_rand(2); step(1'b1);
    post_rand(1); post_rand(2);
    step(1'b1);
    step(1'b1);
    post_rand(1);
    step(1'b1);
    step(1'b1);

    // Reset while a response is held, then restart from requester 0.
    for (int i = 0; i < N; i++) post_rand(i);
    step(1'b1);
    apply_reset();
    for (int i = 0; i < N; i++) post_rand(i);
    step(1'b1);
    step(1'b1);

    // Randomized traffic with random backpressure.
    for (int r = 0; r < 400; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          if ($urandom_range(0, 7) == 0) post(i, {W{1'b1}}, W'($urandom_range(1, 255)));
          else post_rand(i);
        end
      end
      step($urandom_range(0, 3) != 0);
    end

    // Drain outstanding requests and responses.
    for (int r = 0; r < 40; r++) begin
      if (sb.size() != 0 || pend[0] || pend[1] || pend[2] || pend[3] || m_hold) step(1'b1);
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/simple_adder_arb_sv.md
Name: simple_adder_arb_sv

Overview:
- Round-robin arbiter and sequencer that shares one W-bit adder between N requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The granted pair is added, and the sum is registered and returned on a single response channel tagged with the requester id.
- Sits between client blocks and the shared adder datapath; the sum is x_0 + x_1 modulo 2^W, plus carry-out.

Parameters:
- W, 8, operand/result width in bits (W >= 1).
- N, 4, number of requesters (N >= 2).
- IW, $clog2(N), width of requester id (derived, not overridden).

Ports:
- clk  input  1  system clock, all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  N  bit i: requester i has an operand pair.
- req_ready  output  N  bit i: pair i accepted this cycle (one-hot or zero).
- req_x_0  input  N*W  operand 0, slice i = bits [i*W +: W].
- req_x_1  input  N*W  operand 1, slice i = bits [i*W +: W].
- resp_valid  output  1  response holds a valid sum.
- resp_ready  input  1  consumer accepts the response.
- resp_id  output  IW  index of the requester that produced the response.
- resp_result  output  W  (x_0 + x_1) mod 2^W.
- resp_carry  output  1  carry-out, bit W of the full sum.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; resp_valid=0, resp_id=0, resp_result=0, resp_carry=0.
  - Round-robin pointer ptr=0; req_ready=0.
- States:
  - IDLE: no response held.
  - HOLD: response registered, resp_valid=1.
- Accept condition: accept = (state==IDLE) or (state==HOLD and resp_ready).
- Grant selection, combinational:
  - The first i with req_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - req_ready[g] = accept and req_valid[g]; all other bits are 0.
  - At most one bit of req_ready is high.
- On a cycle with accept and any req_valid:
  - Register resp_result/resp_carry from {1'b0,x_0[g]} + {1'b0,x_1[g]} (W+1-bit sum).
  - resp_id <= g; resp_valid <= 1; state <= HOLD.
  - ptr <= (g+1) mod N, wrapping from N-1 to 0.
- On a cycle with accept and no req_valid:
  - resp_valid <= 0; state <= IDLE; ptr unchanged.
- HOLD with resp_ready=0: all response outputs stable, req_ready=0, ptr unchanged. Backpressure holds indefinitely.
- Latency and throughput:
  - Request accepted in cycle T gives resp_valid=1 with its sum in cycle T+1.
  - Full throughput is one op per cycle while resp_ready=1.
- Requester handshake rule: a requester keeps req_valid and operands stable until it sees req_ready. The block samples operands only in the accept cycle.
- Simultaneous response handoff and new grant in the same cycle (HOLD with resp_ready=1): legal; the new result replaces the old one with no bubble.
- Fairness: a continuously requesting client is granted within N accepts.
- Reset mid-operation: the pending response is discarded and ptr returns to 0. Requesters must re-present.
- Adder overflow: the result wraps and resp_carry=1. No saturation.

Test Plan:
- Reset, then a single request. Reset with all inputs 0 -> resp_valid=0, req_ready=0. Then req_valid=0001, W=8, x_0=0x12, x_1=0x34 -> req_ready=0001 in cycle T; resp_valid=1, id=0, result=0x46, carry=0 in T+1.
- Overflow. Requester 2: x_0=0xFF, x_1=0x01 -> result=0x00, carry=1, id=2. Then 0x80+0x80 -> result=0x00, carry=1.
- Round robin. All four requesting continuously with resp_ready=1 -> grants 0,1,2,3,0,1, one per cycle; resp_id sequence follows one cycle later.
- Backpressure. resp_valid=1 and resp_ready=0 held 5 cycles with requests pending -> outputs stable, req_ready=0. On resp_ready=1 the next grant occurs in the same cycle and the new response appears the next cycle.
- Pointer skip and wrap. ptr=3, req_valid=0110 -> grant 1, ptr becomes 2. Then requests only on 1 -> grant 1 (wraps past 3 and 0).
- Reset during HOLD. resetn pulsed low while resp_valid=1 -> resp_valid falls immediately, without waiting for a clock edge. After release, with all requesting -> first grant is 0.
